// File: rtl/package_settings.sv
// Shared system-wide settings for the v6 signal chain.
package package_settings;
  localparam int SIZE_ADC_DATA = 14;
endpackage

// File: rtl/v6_pulse_pkg.sv
// Types and constants for the v6 synthetic pulse source.
package v6_pulse_pkg;
  import package_settings::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    DECAY = 2'd2
  } state_t;

  localparam int FRAC_W_DEF = 8;
  localparam int ACC_W      = SIZE_ADC_DATA + FRAC_W_DEF + 1;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
endpackage

// File: rtl/v6_pulse_lfsr.sv
// 16-bit Galois LFSR used as a cheap dither source for the pulse generator.
module v6_pulse_lfsr
  import v6_pulse_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/v6_pulse_source.sv
// Synthetic detector pulse generator (linear rise, exponential decay, pile-up).
// Optional baseline dither when V6_PULSE_SOURCE_NOISE_EN is defined.
module v6_pulse_source
  import package_settings::*;
  import v6_pulse_pkg::*;
#(
  parameter int RISE_SHIFT  = 2,
  parameter int DECAY_SHIFT = 4,
  parameter int PERIOD      = 256,
  parameter int BASELINE    = 100,
  parameter int FRAC_W      = FRAC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  input  logic [15:0]              n_pulses,
  output logic [SIZE_ADC_DATA-1:0] adc_data,
  output logic                     pulse_strobe,
  output logic                     busy,
  output logic                     done
);

  localparam int AW       = ACC_W + FRAC_W - FRAC_W_DEF;
  localparam int RISE_LEN = 1 << RISE_SHIFT;
  localparam int PC_W     = $clog2(PERIOD);
  localparam int ADC_MAX  = (1 << SIZE_ADC_DATA) - 1;
  localparam logic [AW-1:0] ACC_MAX = '1;

  state_t                   state;
  logic [AW-1:0]            acc;
  logic [AW-1:0]            base;
  logic [PC_W-1:0]          pc;
  logic [15:0]              rem;
  logic [SIZE_ADC_DATA-1:0] amp;

  logic [AW-1:0]            amp_full;
  logic [AW-1:0]            rise_step;
  logic [AW-1:0]            acc_decayed;
  logic [AW-1:0]            rise_base;
  logic signed [31:0]       level;

  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[AW] ? ACC_MAX : s[AW-1:0];
  endfunction

  function automatic logic [SIZE_ADC_DATA-1:0] sat_adc(input logic signed [31:0] v);
    if (v < 0)
      return '0;
    else if (v > ADC_MAX)
      return SIZE_ADC_DATA'(ADC_MAX);
    else
      return v[SIZE_ADC_DATA-1:0];
  endfunction

  always_comb begin
    amp_full    = {1'b0, amp, {FRAC_W{1'b0}}};
    rise_step   = amp_full >> RISE_SHIFT;
    acc_decayed = acc - (acc >> DECAY_SHIFT);
    // The first RISE cycle still holds the pre-pulse level in acc itself.
    rise_base   = (pc == '0) ? acc : base;
  end

`ifdef V6_PULSE_SOURCE_NOISE_EN
  logic [15:0] lfsr;

  v6_pulse_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .state (lfsr)
  );

  always_comb begin
    level = 32'(BASELINE) + 32'(acc[AW-1:FRAC_W]) + 32'(signed'(lfsr[2:0]));
  end
`else
  always_comb begin
    level = 32'(BASELINE) + 32'(acc[AW-1:FRAC_W]);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= '0;
      base         <= '0;
      pc           <= '0;
      rem          <= '0;
      amp          <= '0;
      adc_data     <= SIZE_ADC_DATA'(BASELINE);
      busy         <= 1'b0;
      done         <= 1'b0;
      pulse_strobe <= 1'b0;
    end else begin
      done         <= 1'b0;
      pulse_strobe <= 1'b0;
      adc_data     <= sat_adc(level);

      case (state)
        IDLE: begin
          if (start) begin
            amp <= amplitude;
            if (n_pulses == 16'd0) begin
              done <= 1'b1;
            end else begin
              state        <= RISE;
              busy         <= 1'b1;
              pc           <= '0;
              rem          <= n_pulses;
              pulse_strobe <= 1'b1;
            end
          end
        end

        RISE: begin
          if (pc == '0)
            base <= acc;
          // Land exactly on base+amp so truncated steps never drift the peak.
          if (pc == PC_W'(RISE_LEN - 1)) begin
            acc   <= sat_add(rise_base, amp_full);
            state <= DECAY;
          end else begin
            acc <= sat_add(acc, rise_step);
          end
          pc <= pc + 1'b1;
        end

        DECAY: begin
          if (pc == PC_W'(PERIOD - 1)) begin
            if (rem > 16'd1) begin
              // Residual tail is kept so the next pulse piles up on it.
              rem          <= rem - 16'd1;
              pc           <= '0;
              state        <= RISE;
              pulse_strobe <= 1'b1;
              acc          <= acc_decayed;
            end else begin
              state <= IDLE;
              acc   <= '0;
              pc    <= '0;
              rem   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            acc <= acc_decayed;
            pc  <= pc + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v6_pulse_source.sv
// Randomized self-checking bench for v6_pulse_source against a behavioural pulse model.
module tb_v6_pulse_source;

  localparam int ADCMAX = 16383;
  localparam longint ACCMAX = (64'd1 << 23) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start8 = 1'b0;
  logic [13:0] amp0 = '0, amp8 = '0;
  logic [15:0] n0 = '0, n8 = '0;
  logic [13:0] adc0, adc8;
  logic        strobe0, strobe8, busy0, busy8, done0, done8;

  int vectors = 0;
  int miscompares = 0;
  int exp_adc[$];
  int trace_adc[$];
  int done_at;
  int done_cnt;
  int strobe_cnt;

  always #5 clk = ~clk;

  v6_pulse_source dut0 (
    .clk(clk), .reset(reset), .start(start0), .amplitude(amp0), .n_pulses(n0),
    .adc_data(adc0), .pulse_strobe(strobe0), .busy(busy0), .done(done0)
  );

  v6_pulse_source #(.PERIOD(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .amplitude(amp8), .n_pulses(n8),
    .adc_data(adc8), .pulse_strobe(strobe8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_adc(input string tag, input int obs, input int expv);
`ifdef V6_PULSE_SOURCE_NOISE_EN
    int hi;
    hi = (expv + 3 > ADCMAX) ? ADCMAX : expv + 3;
    vectors++;
    assert (obs >= expv - 4 && obs <= hi) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d(+-4)", tag, obs, expv);
    end
`else
    chk(tag, obs, expv);
`endif
  endtask

  function automatic int to_adc(input longint a);
    longint v;
    v = 100 + (a >> 8);
    return (v > ADCMAX) ? ADCMAX : int'(v);
  endfunction

  // Expected adc_data per cycle, index 0 being the cycle of the first strobe.
  task automatic build_expected(input int amp, input int n, input int period);
    longint acc, base, full;
    int np, ph;
    np = n * period;
    full = longint'(amp) << 8;
    acc = 0;
    base = 0;
    exp_adc.delete();
    exp_adc.push_back(to_adc(0));
    for (int k = 0; k <= np; k++) begin
      exp_adc.push_back(to_adc(acc));
      if (k == np) break;
      ph = k % period;
      if (ph == 0) base = acc;
      if (ph < 4) begin
        if (ph == 3) acc = base + full;
        else acc = acc + (full >> 2);
        if (acc > ACCMAX) acc = ACCMAX;
      end else if (k == np - 1) begin
        acc = 0;
      end else begin
        acc = acc - (acc >> 4);
      end
    end
  endtask

  task automatic drive(input bit sel, input bit s, input int a, input int n);
    if (sel) begin
      start8 = s; amp8 = a[13:0]; n8 = n[15:0];
    end else begin
      start0 = s; amp0 = a[13:0]; n0 = n[15:0];
    end
  endtask

  task automatic run_burst(input bit sel, input int amp, input int n, input bit poke);
    int period, np, oa, ob, os, od;
    period = sel ? 8 : 256;
    np = n * period;
    build_expected(amp, n, period);
    trace_adc.delete();
    done_at = -1;
    done_cnt = 0;
    strobe_cnt = 0;
    @(negedge clk);
    drive(sel, 1'b1, amp, n);
    @(negedge clk);
    for (int j = 0; j <= np + 1; j++) begin
      oa = sel ? int'(adc8) : int'(adc0);
      ob = sel ? int'(busy8) : int'(busy0);
      os = sel ? int'(strobe8) : int'(strobe0);
      od = sel ? int'(done8) : int'(done0);
      trace_adc.push_back(oa);
      if (od == 1) begin done_cnt++; if (done_at < 0) done_at = j; end
      if (os == 1) strobe_cnt++;
      chk_adc($sformatf("adc[%0d]", j), oa, exp_adc[j]);
      chk($sformatf("busy[%0d]", j), ob, (j < np) ? 1 : 0);
      chk($sformatf("strobe[%0d]", j), os, (j < np && j % period == 0) ? 1 : 0);
      chk($sformatf("done[%0d]", j), od, (j == np) ? 1 : 0);
      if (poke && (j == np / 2 || j == np - 1))
        drive(sel, 1'b1, int'($urandom_range(0, ADCMAX)), int'($urandom_range(0, 5)));
      else
        drive(sel, 1'b0, int'($urandom_range(0, ADCMAX)), int'($urandom_range(0, 5)));
      @(negedge clk);
    end
    drive(sel, 1'b0, 0, 0);
    chk("done_count", done_cnt, 1);
    chk("strobe_count", strobe_cnt, n);
  endtask

  initial begin
    int maxv;
    // Reset held three cycles.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_adc("rst_adc0", int'(adc0), 100);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_strobe0", int'(strobe0), 0);
    chk_adc("rst_adc8", int'(adc8), 100);
    chk("rst_busy8", int'(busy8), 0);

    // Single default pulse with known sample values.
    run_burst(1'b0, 1000, 1, 1'b0);
`ifndef V6_PULSE_SOURCE_NOISE_EN
    chk("rise0", trace_adc[2], 350);
    chk("rise1", trace_adc[3], 600);
    chk("rise2", trace_adc[4], 850);
    chk("peak", trace_adc[5], 1100);
    chk("decay0", trace_adc[6], 1037);
`endif
    chk("done_at", done_at, 256);

    // Zero-pulse request.
    @(negedge clk);
    drive(1'b0, 1'b1, 500, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 0);
    chk("n0_done", int'(done0), 1);
    chk("n0_busy", int'(busy0), 0);
    chk_adc("n0_adc", int'(adc0), 100);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("n0_done_after", int'(done0), 0);
      chk("n0_busy_after", int'(busy0), 0);
      chk("n0_strobe_after", int'(strobe0), 0);
      chk_adc("n0_adc_after", int'(adc0), 100);
    end

    // Pile-up with short period.
    run_burst(1'b1, 1000, 3, 1'b0);
    vectors++;
    assert (trace_adc[13] > 1100) else begin
      miscompares++;
      $error("FAIL pileup_peak observed=%0d expected=>1100", trace_adc[13]);
    end
    run_burst(1'b1, 16383, 6, 1'b1);
    maxv = 0;
    foreach (trace_adc[i]) if (trace_adc[i] > maxv) maxv = trace_adc[i];
    chk("sat_max", maxv, ADCMAX);

    // Starts during the burst and on the final expiry are ignored.
    run_burst(1'b0, int'($urandom_range(1, ADCMAX)), 2, 1'b1);
    for (int r = 0; r < 6; r++)
      run_burst(1'b1, int'($urandom_range(0, ADCMAX)), int'($urandom_range(1, 7)), r[0]);
    run_burst(1'b0, int'($urandom_range(0, 4000)), int'($urandom_range(1, 2)), 1'b1);

    // Reset in the middle of a decay tail.
    @(negedge clk);
    drive(1'b0, 1'b1, 2000, 2);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 0);
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", int'(busy0), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_adc("midrst_adc", int'(adc0), 100);
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_done", int'(done0), 0);
    done_cnt = 0;
    maxv = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done0 || busy0 || strobe0) done_cnt++;
      if (int'(adc0) > maxv) maxv = int'(adc0);
    end
    chk("midrst_quiet", done_cnt, 0);
`ifdef V6_PULSE_SOURCE_NOISE_EN
    chk("midrst_idle_max_ok", (maxv <= 103) ? 1 : 0, 1);
`else
    chk("midrst_idle_max", maxv, 100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
